// File: rtl/ripple_sum_capture.sv
// Sequencer around a 4-bit ripple-carry adder: launches operands, waits a settle
// time, captures {cout,sum}, checks it against a reference and accumulates it.
module ripple_sum_capture #(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned ACC_WIDTH     = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [3:0]           in_a,
    input  logic [3:0]           in_b,
    input  logic                 in_cin,
    output logic [3:0]           add_a,
    output logic [3:0]           add_b,
    output logic                 add_cin,
    input  logic [3:0]           add_sum,
    input  logic                 add_cout,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [4:0]           out_sum,
    input  logic                 clear,
    output logic [ACC_WIDTH-1:0] acc,
    output logic                 acc_ovf,
    output logic                 mismatch
);

    typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

    state_t               state_q, state_d;
    logic [3:0]           cnt_q, cnt_d;
    logic [3:0]           a_q, a_d, b_q, b_d;
    logic                 cin_q, cin_d;
    logic [4:0]           ref_q, ref_d;
    logic [4:0]           sum_q, sum_d;
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic                 ovf_q, ovf_d;
    logic                 mis_q, mis_d;

    logic                 capture;
    logic [4:0]           cap_val;
    logic                 cap_diff;
    logic [ACC_WIDTH:0]   acc_sum;

    assign capture  = (state_q == SETTLE) && (cnt_q == 4'd0);
    assign cap_val  = {add_cout, add_sum};
    assign cap_diff = (cap_val != ref_q);
    assign acc_sum  = {1'b0, acc_q} + (ACC_WIDTH + 1)'(cap_val);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        cin_d   = cin_q;
        ref_d   = ref_q;
        sum_d   = sum_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    cin_d   = in_cin;
                    ref_d   = {1'b0, in_a} + {1'b0, in_b} + {4'b0, in_cin};
                    cnt_d   = 4'(SETTLE_CYCLES - 1);
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt_q == 4'd0) begin
                    sum_d   = cap_val;
                    state_d = HOLD;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            HOLD: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // A clear on a capture edge restarts the statistics from that capture alone.
    always_comb begin
        acc_d = acc_q;
        ovf_d = ovf_q;
        mis_d = mis_q;
        if (clear) begin
            acc_d = capture ? ACC_WIDTH'(cap_val) : '0;
            ovf_d = 1'b0;
            mis_d = capture && cap_diff;
        end else if (capture) begin
            acc_d = acc_sum[ACC_WIDTH-1:0];
            ovf_d = ovf_q | acc_sum[ACC_WIDTH];
            mis_d = mis_q | cap_diff;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            cin_q   <= 1'b0;
            ref_q   <= '0;
            sum_q   <= '0;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cin_q   <= cin_d;
            ref_q   <= ref_d;
            sum_q   <= sum_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
            mis_q   <= mis_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == HOLD);
    assign add_a     = a_q;
    assign add_b     = b_q;
    assign add_cin   = cin_q;
    assign out_sum   = sum_q;
    assign acc       = acc_q;
    assign acc_ovf   = ovf_q;
    assign mismatch  = mis_q;

endmodule

// File: tb/tb_ripple_sum_capture.sv
// Bench for ripple_sum_capture: behavioural adder plus an arithmetic model of the
// accumulator/sticky flags; table vectors, corner sequences and random traffic.
module tb_ripple_sum_capture;

    localparam int unsigned S = 2;
    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst, in_valid, in_ready, in_cin, add_cin, add_cout;
    logic [3:0]   in_a, in_b, add_a, add_b, add_sum;
    logic         out_valid, out_ready, clear, acc_ovf, mismatch;
    logic [4:0]   out_sum;
    logic [W-1:0] acc;
    logic         fault;

    int checks = 0;
    int errors = 0;
    int acc_m = 0;
    bit ovf_m = 1'b0;
    bit mis_m = 1'b0;

    ripple_sum_capture #(.SETTLE_CYCLES(S), .ACC_WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_sum(add_sum), .add_cout(add_cout),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
        .clear(clear), .acc(acc), .acc_ovf(acc_ovf), .mismatch(mismatch)
    );

    always #5 clk = ~clk;

    logic [4:0] adder_res;
    assign adder_res          = fault ? 5'd0 : ({1'b0, add_a} + {1'b0, add_b} + {4'd0, add_cin});
    assign {add_cout, add_sum} = adder_res;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       c;
        logic [4:0] sum;
    } vec_t;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_stats(input string tag);
        chk({tag, "_acc"}, 32'(acc), 32'(acc_m));
        chk({tag, "_ovf"}, 32'(acc_ovf), 32'(ovf_m));
        chk({tag, "_mis"}, 32'(mismatch), 32'(mis_m));
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
        acc_m = 0; ovf_m = 1'b0; mis_m = 1'b0;
        chk_stats("clear");
    endtask

    // One transaction; hold = cycles of out_ready low after capture, during which
    // different operands are offered and must be ignored.
    task automatic txn(input logic [3:0] a, input logic [3:0] b, input logic c,
                       input int hold, input bit clr_cap);
        int         n;
        int         expv, refv;
        n = 0;
        while (!in_ready && n < 20) begin step(); n++; end
        if (!in_ready) chk("accept_timeout", 32'(in_ready), 32'd1);
        in_valid = 1'b1; in_a = a; in_b = b; in_cin = c;
        step();
        in_valid = 1'b0;
        chk("launch_a", 32'(add_a), 32'(a));
        chk("launch_b", 32'(add_b), 32'(b));
        chk("launch_cin", 32'(add_cin), 32'(c));
        chk("settle_ready", 32'(in_ready), 32'd0);
        repeat (S - 1) begin
            chk("settle_valid", 32'(out_valid), 32'd0);
            step();
        end
        out_ready = (hold == 0);
        clear = clr_cap;
        step();
        clear = 1'b0;
        refv = int'(a) + int'(b) + int'(c);
        expv = fault ? 0 : refv;
        if (clr_cap) begin
            acc_m = expv; ovf_m = 1'b0; mis_m = (expv != refv);
        end else begin
            acc_m += expv;
            if (acc_m >= (1 << W)) begin acc_m -= (1 << W); ovf_m = 1'b1; end
            if (expv != refv) mis_m = 1'b1;
        end
        chk("cap_valid", 32'(out_valid), 32'd1);
        chk("cap_sum", 32'(out_sum), 32'(expv));
        chk_stats("cap");
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1; in_a = ~a; in_b = ~b; in_cin = ~c;
            step();
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_sum", 32'(out_sum), 32'(expv));
            chk("bp_ready", 32'(in_ready), 32'd0);
            chk("bp_add_a", 32'(add_a), 32'(a));
        end
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        chk("done_valid", 32'(out_valid), 32'd0);
        chk("done_ready", 32'(in_ready), 32'd1);
        chk("done_sum_held", 32'(out_sum), 32'(expv));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1);
    end

    initial begin
        vec_t tbl[6];
        tbl[0] = '{a: 4'd1,  b: 4'd1,  c: 1'b0, sum: 5'd2};
        tbl[1] = '{a: 4'd15, b: 4'd15, c: 1'b1, sum: 5'd31};
        tbl[2] = '{a: 4'd0,  b: 4'd0,  c: 1'b0, sum: 5'd0};
        tbl[3] = '{a: 4'd7,  b: 4'd8,  c: 1'b1, sum: 5'd16};
        tbl[4] = '{a: 4'd15, b: 4'd0,  c: 1'b1, sum: 5'd16};
        tbl[5] = '{a: 4'd10, b: 4'd5,  c: 1'b0, sum: 5'd15};

        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0;
        out_ready = 1'b1; clear = 1'b0; fault = 1'b0;
        step();
        chk("rst_ready", 32'(in_ready), 32'd1);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_add_a", 32'(add_a), 32'd0);
        chk("rst_add_b", 32'(add_b), 32'd0);
        chk("rst_add_cin", 32'(add_cin), 32'd0);
        chk("rst_sum", 32'(out_sum), 32'd0);
        chk_stats("rst");
        step();
        rst = 1'b0;
        step();

        for (int i = 0; i < 6; i++) begin
            txn(tbl[i].a, tbl[i].b, tbl[i].c, 0, 1'b0);
            chk("tbl_sum", 32'(out_sum), 32'(tbl[i].sum));
            chk("tbl_hold_a", 32'(add_a), 32'(tbl[i].a));
            chk("tbl_hold_b", 32'(add_b), 32'(tbl[i].b));
            chk("tbl_hold_cin", 32'(add_cin), 32'(tbl[i].c));
            if (i == 0) chk("basic_acc", 32'(acc), 32'd2);
        end

        do_clear();
        for (int i = 1; i <= 9; i++) begin
            txn(4'd15, 4'd15, 1'b1, 0, 1'b0);
            if (i == 8) begin
                chk("wrap8_acc", 32'(acc), 32'd248);
                chk("wrap8_ovf", 32'(acc_ovf), 32'd0);
            end
            if (i == 9) begin
                chk("wrap9_acc", 32'(acc), 32'd23);
                chk("wrap9_ovf", 32'(acc_ovf), 32'd1);
            end
        end

        txn(4'd2, 4'd2, 1'b0, 0, 1'b1);
        chk("clrcap_acc", 32'(acc), 32'd4);
        chk("clrcap_ovf", 32'(acc_ovf), 32'd0);

        fault = 1'b1;
        txn(4'd3, 4'd4, 1'b0, 0, 1'b0);
        chk("fault_sum", 32'(out_sum), 32'd0);
        chk("fault_mis", 32'(mismatch), 32'd1);
        repeat (3) step();
        chk("fault_sticky", 32'(mismatch), 32'd1);
        fault = 1'b0;
        do_clear();
        chk("fault_clr_mis", 32'(mismatch), 32'd0);
        chk("fault_clr_acc", 32'(acc), 32'd0);

        txn(4'd3, 4'd9, 1'b0, 5, 1'b0);
        txn(4'd12, 4'd6, 1'b1, 0, 1'b0);
        chk("bp_next_a", 32'(add_a), 32'd12);

        in_valid = 1'b1; in_a = 4'd5; in_b = 4'd3; in_cin = 1'b0;
        step();
        in_valid = 1'b0;
        chk("abort_launch", 32'(add_a), 32'd5);
        step();
        rst = 1'b1;
        #1;
        acc_m = 0; ovf_m = 1'b0; mis_m = 1'b0;
        chk("abort_valid", 32'(out_valid), 32'd0);
        chk("abort_add_a", 32'(add_a), 32'd0);
        chk_stats("abort");
        step();
        rst = 1'b0;
        repeat (S + 2) step();
        chk("abort_no_cap", 32'(out_valid), 32'd0);
        chk("abort_sum", 32'(out_sum), 32'd0);
        chk("abort_acc", 32'(acc), 32'd0);

        for (int i = 0; i < 30; i++) begin
            txn(4'($urandom_range(15)), 4'($urandom_range(15)), 1'($urandom_range(1)),
                int'($urandom_range(2)), ($urandom_range(7) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
